apb_mem_slave: RTL and testbench
================================

// Module: apb_mem_slave
// PURPOSE
// - APB slave with a word-organised on-chip memory, used as a bus target in APB subsystem benches and SoCs.
// - One instance per PSEL line of an APB bridge/master.
// - Accepts single transfers, inserts DELAY wait states per access, flags out-of-range accesses via PSLVERR.
// PARAMETERS
// - SIZE_IN_BYTES  1024  memory capacity in bytes; power of two, >=4; depth = SIZE_IN_BYTES/4 32-bit words
// - DELAY          0     wait states inserted in every access phase (0 = zero-wait)
// PORTS
// - PCLK     in   1   clock; all state updates on rising edge
// - PRESET   in   1   reset, synchronous, active-high
// - PSEL     in   1   slave select
// - PADDR    in   32  byte address; PADDR[1:0] ignored
// - PENABLE  in   1   access-phase indicator
// - PWRITE   in   1   1=write, 0=read
// - PWDATA   in   32  write data
// - PRDATA   out  32  read data
// - PREADY   out  1   transfer completion
// - PSLVERR  out  1   transfer error, valid only when PREADY=1 in access phase
// - PPROT    in   3   protection type (APB4_EN only; accepted, no effect)
// - PSTRB    in   4   write byte strobes (APB4_EN only)
// BEHAVIOUR
// - Phases: setup = PSEL & !PENABLE; access = PSEL & PENABLE; complete = access & PREADY.
// - Wait counter cnt (width clog2(DELAY+1), min 1):
//   - cleared by reset, on complete, and whenever !PSEL;
//   - in access with cnt<DELAY: cnt<=cnt+1.
//   - PREADY = (cnt==DELAY), combinational.
//   - Access therefore lasts DELAY+1 cycles; DELAY=0 -> PREADY constantly 1.
// - Address decode: word index = PADDR[clog2(SIZE_IN_BYTES)-1:2].
//   - In range iff PADDR < SIZE_IN_BYTES; no wrap-around aliasing.
// - Write: on complete & PWRITE & in range, mem[index] <= PWDATA (lane gating per CONFIGURATION) at that clock edge.
// - Read: PRDATA = mem[index] combinationally during access & !PWRITE & in range; otherwise 32'h0.
// - PSLVERR = access & PREADY & out-of-range. Out-of-range write: memory unchanged. Out-of-range read: PRDATA=0.
// - Reset (any cycle, incl. mid-access) has priority:
//   - cnt=0; no memory write in a reset cycle.
//   - Outputs while reset held with bus idle: PRDATA=0, PSLVERR=0, PREADY=(DELAY==0).
//   - Memory contents are not cleared by reset.
// - Back-to-back transfers (setup directly after complete) need no idle cycle.
// - PSEL dropped mid-access aborts: cnt cleared, no write.
// - Read-after-write to the same word in consecutive transfers returns the new data.
// CONFIGURATION
// - Macro APB4_EN defined:
//   - PPROT/PSTRB ports exist.
//   - Byte lane i (PWDATA[8i+7:8i]) written only if PSTRB[i]=1; PSTRB=0 write leaves memory unchanged but still completes.
//   - Reads ignore PSTRB.
// - Macro APB4_EN undefined: PPROT/PSTRB absent; every write updates all 4 bytes.
// TESTING
// - DELAY=0, write 0xDEADBEEF @0x10, then read @0x10 -> PREADY=1 every access, PRDATA=0xDEADBEEF, PSLVERR=0.
// - DELAY=3, write then read @0x3FC -> PREADY low 3 access cycles, high on 4th; readback 0x3FC data matches.
// - Read @0x400 (SIZE 1024) -> PSLVERR=1 on completion, PRDATA=0; write @0x400 leaves mem[0] unchanged.
// - APB4_EN: write 0x11223344 PSTRB=4'hF, then 0xAABBCCDD PSTRB=4'b0101 -> read 0x11BB33DD.
// - Reset asserted mid-access (DELAY=2) -> cnt cleared, no write; first post-reset transfer takes DELAY+1 access cycles.
// - Walk all 256 words with address-as-data, back-to-back transfers -> every readback equals its byte address.

Source files
------------

// File: rtl/apb_mem_slave.sv
// APB slave backed by a word-organised memory with DELAY wait states per access.
// Define APB4_EN to add the PPROT/PSTRB ports and per-byte write strobes.
module apb_mem_slave #(
  parameter int SIZE_IN_BYTES = 1024,
  parameter int DELAY         = 0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
`ifdef APB4_EN
  ,
  input  logic [2:0]  PPROT,
  input  logic [3:0]  PSTRB
`endif
);

  localparam int DEPTH = SIZE_IN_BYTES / 4;
  localparam int AW    = $clog2(SIZE_IN_BYTES);
  localparam int IW    = (AW > 2) ? AW - 2 : 1;
  localparam int CW    = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam logic [CW-1:0] DELAY_C = CW'(DELAY);

  logic [31:0]   mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          access;
  logic          complete;
  logic          in_range;

  // A single-word memory has no index bits to decode.
  generate
    if (AW > 2) begin : g_idx
      assign idx = PADDR[AW-1:2];
    end else begin : g_idx_single
      assign idx = '0;
    end
  endgenerate

`ifdef APB4_EN
  logic unused_prot;
  assign unused_prot = ^PPROT;
`endif

  assign access   = PSEL && PENABLE;
  assign in_range = (PADDR < 32'(SIZE_IN_BYTES));
  assign PREADY   = (cnt == DELAY_C);
  assign complete = access && PREADY;
  assign PSLVERR  = complete && !in_range;
  assign PRDATA   = (access && !PWRITE && in_range) ? mem[idx] : 32'h0;

  // cnt never exceeds DELAY, so !PREADY is the same as cnt < DELAY.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt <= '0;
    end else if (!PSEL || complete) begin
      cnt <= '0;
    end else if (access && !PREADY) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Memory has no reset; a reset cycle suppresses any pending write.
  always_ff @(posedge PCLK) begin
    if (!PRESET && complete && PWRITE && in_range) begin
`ifdef APB4_EN
      for (int i = 0; i < 4; i++) begin
        if (PSTRB[i]) mem[idx][8*i +: 8] <= PWDATA[8*i +: 8];
      end
`else
      mem[idx] <= PWDATA;
`endif
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: a zero-wait and a three-wait instance share one APB bus.
// Expected responses are queued by the driver and checked by a completion monitor.
module tb_apb_mem_slave;

  localparam int W = 41;  // {wait_cycles[7:0], pslverr, prdata[31:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = 4'hF;
  logic [2:0]  pprot = 3'b000;
  logic        dsel = 1'b0;  // 0 selects the DELAY=0 slave, 1 the DELAY=3 slave

  logic        psel0, psel3;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic        mon_ready, mon_err;
  logic [31:0] mon_data;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           failures = 0;
  logic [7:0]   waits = '0;

  assign psel0     = psel && !dsel;
  assign psel3     = psel && dsel;
  assign mon_ready = dsel ? pready3 : pready0;
  assign mon_err   = dsel ? pslverr3 : pslverr0;
  assign mon_data  = dsel ? prdata3 : prdata0;

  apb_mem_slave #(.SIZE_IN_BYTES(1024), .DELAY(0)) dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0)
`ifdef APB4_EN
    , .PPROT(pprot), .PSTRB(pstrb)
`endif
  );

  apb_mem_slave #(.SIZE_IN_BYTES(1024), .DELAY(3)) dut3 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel3), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata3), .PREADY(pready3),
    .PSLVERR(pslverr3)
`ifdef APB4_EN
    , .PPROT(pprot), .PSTRB(pstrb)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Completion monitor: counts wait cycles and compares against the queue head.
  always @(negedge clk) begin
    if (rst || !psel) begin
      waits = '0;
    end else if (penable) begin
      if (!mon_ready) begin
        waits = waits + 8'd1;
      end else begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 64'd1, 64'd0);
        end else begin
          check("xfer", 64'({waits, mon_err, mon_data}), 64'(exp_q.pop_front()));
        end
        waits = '0;
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the completing edge with the bus idle,
  // so a following call starts its setup phase with no idle cycle in between.
  task automatic xfer(input logic s, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] exp_data, input logic exp_err);
    int n;
    exp_q.push_back({(s ? 8'd3 : 8'd0), exp_err, exp_data});
    dsel = s; psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (!mon_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    cycles(2);
    check("rst_pready0", 64'(pready0), 64'd1);
    check("rst_pready3", 64'(pready3), 64'd0);
    check("rst_prdata0", 64'(prdata0), 64'd0);
    check("rst_prdata3", 64'(prdata3), 64'd0);
    check("rst_pslverr0", 64'(pslverr0), 64'd0);
    check("rst_pslverr3", 64'(pslverr3), 64'd0);
    rst = 1'b0;
    cycles(1);

    // Zero-wait write then read, back to back
    xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

    // Out-of-range accesses must not alias onto word 0
    xfer(1'b0, 1'b1, 32'h0, 32'h12345678, 4'hF, 32'h0, 1'b0);
    xfer(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1);
    xfer(1'b0, 1'b1, 32'h400, 32'hBAD0BAD0, 4'hF, 32'h0, 1'b1);
    xfer(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 32'h12345678, 1'b0);
    xfer(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 32'h0, 1'b1);
    cycles(1);

    // Walk every word with address-as-data
    for (int i = 0; i < 256; i++) xfer(1'b0, 1'b1, 32'(i * 4), 32'(i * 4), 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 256; i++) xfer(1'b0, 1'b0, 32'(i * 4), 32'h0, 4'hF, 32'(i * 4), 1'b0);
    cycles(1);

`ifdef APB4_EN
    xfer(1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF, 32'h0, 1'b0);
    xfer(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    xfer(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    xfer(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    xfer(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 32'h11BB33DD, 1'b0);
    cycles(1);
`endif

    // Three-wait slave: top word and out-of-range read
    xfer(1'b1, 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    xfer(1'b1, 1'b0, 32'h3FC, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);
    xfer(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1);
    xfer(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
    cycles(1);

    // Reset two cycles into an access: counter must restart from zero
    dsel = 1'b1; psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    cycles(1);
    penable = 1'b1;
    cycles(2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("rst_mid_cnt_clear", 64'(pready3), 64'd0);
    cycles(1);
    psel = 1'b0; penable = 1'b0;
    cycles(1);

    // Reset on the completing cycle: the write must be dropped
    psel = 1'b1;
    cycles(1);
    penable = 1'b1;
    cycles(3);
    check("rst_complete_ready", 64'(pready3), 64'd1);
    rst = 1'b1;
    cycles(1);
    check("rst_complete_cnt", 64'(pready3), 64'd0);
    rst = 1'b0;
    psel = 1'b0; penable = 1'b0;
    cycles(1);

    // First post-reset transfer takes DELAY+1 access cycles; memories survive reset
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h10, 1'b0);
    cycles(2);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      cycles(1);
      n++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
